// File: rtl/core_launch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : core_launch_ctrl
//  Purpose  : Sequences task launches onto a core array, honouring busy cores
//             and ACQ/REL fences, and tracks per-core busy state.
//  Revision : 1.0  initial release
// ============================================================================
module core_launch_ctrl #(
    parameter int CORE_NUM = 16,
    parameter int WAIT_MAX = 1023,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                task_valid,
    output logic                task_ready,
    input  logic [CORE_NUM-1:0] task_mask,
    input  logic [1:0]          task_fence,
    output logic [CORE_NUM-1:0] core_start,
    input  logic [CORE_NUM-1:0] core_done,
    output logic [CORE_NUM-1:0] core_ready,
    output logic [CORE_NUM-1:0] busy_mask,
    output logic                stall,
    output logic                stall_timeout,
    output logic                spurious_done,
    output logic [CNT_W-1:0]    launch_cnt
);

    localparam int                STALL_W    = $clog2(WAIT_MAX + 1);
    localparam logic [STALL_W-1:0] WAIT_LIMIT = STALL_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_LAUNCH = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CORE_NUM-1:0] mask_q, mask_d;
    logic [1:0]          fence_q, fence_d;
    logic [CORE_NUM-1:0] busy_q, busy_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic                timeout_q, timeout_d;
    logic                spurious_q, spurious_d;
    logic [CNT_W-1:0]    launch_cnt_q, launch_cnt_d;
    logic                blocked;

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        fence_d      = fence_q;
        stall_cnt_d  = stall_cnt_q;
        launch_cnt_d = launch_cnt_q;
        core_start   = '0;
        stall        = 1'b0;
        // ACQ fence (bit 0) needs the whole array idle, not just the task's cores
        blocked      = (|(mask_q & busy_q)) | (fence_q[0] & (|busy_q));

        case (state_q)
            S_IDLE: begin
                if (task_valid) begin
                    mask_d      = task_mask;
                    fence_d     = task_fence;
                    stall_cnt_d = '0;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (blocked) begin
                    stall = 1'b1;
                    if (stall_cnt_q != WAIT_LIMIT)
                        stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                core_start   = mask_q;
                launch_cnt_d = launch_cnt_q + CNT_W'(1);
                state_d      = fence_q[1] ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!(|(mask_q & busy_q)))
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // start wins over a same-cycle done so a relaunched core stays busy
        busy_d     = (busy_q & ~core_done) | core_start;
        spurious_d = spurious_q | (|(core_done & ~busy_q));
        timeout_d  = timeout_q | (stall && (stall_cnt_d == WAIT_LIMIT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            fence_q      <= '0;
            busy_q       <= '0;
            stall_cnt_q  <= '0;
            timeout_q    <= 1'b0;
            spurious_q   <= 1'b0;
            launch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            fence_q      <= fence_d;
            busy_q       <= busy_d;
            stall_cnt_q  <= stall_cnt_d;
            timeout_q    <= timeout_d;
            spurious_q   <= spurious_d;
            launch_cnt_q <= launch_cnt_d;
        end
    end

    assign task_ready    = (state_q == S_IDLE);
    assign busy_mask     = busy_q;
    assign core_ready    = ~busy_q;
    assign stall_timeout = timeout_q;
    assign spurious_done = spurious_q;
    assign launch_cnt    = launch_cnt_q;

endmodule
`default_nettype wire
